alu_uart_frontend: RTL and testbench

Sequential front-end that feeds the combinational ALU from a byte-serial link and returns its result over the same link. It assembles operand A, operand B and the opcode from bytes delivered by the UART receiver, drives them onto the ALU inputs and captures the ALU result and Zero flag. It then serialises the result back to the UART transmitter, one byte per `tx_start`/`tx_done` handshake. The block sits between the UART RX/TX pair and the ALU in the top-level board design.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_uart_frontend.sv | 153 +++++++++++++++
 tb/tb_alu_uart_frontend.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by alu_uart_frontend and the ALU.
//   fe_state_e - front-end FSM states
//   ALU_*      - 4-bit ALU select codes
package alu_pkg;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    EXEC,
    TX_WAIT
  } fe_state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SRA = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1011;

endpackage

// File: rtl/alu_uart_frontend.sv
// alu_uart_frontend: assembles A, B (LSB byte first) and an opcode byte from
// the UART receiver, presents them to the ALU, captures the result and Zero
// flag, and returns the result byte-by-byte over the UART transmitter.
// Ports:
//   clk, rst              - clock, async active-high reset
//   rx_done, rx_data      - received byte strobe and data
//   tx_done               - transmitter finished current byte
//   tx_start, tx_data     - transmit request pulse and byte
//   alu_a, alu_b, alu_op  - registered ALU operands and select
//   alu_result, alu_zero  - ALU outputs
//   zero_flag             - Zero captured with the last result
//   busy                  - opcode accepted until last result byte done
module alu_uart_frontend
  import alu_pkg::*;
#(
  parameter int unsigned bits        = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_done,
  input  logic [7:0]      rx_data,
  input  logic            tx_done,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic [bits-1:0] alu_a,
  output logic [bits-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [bits-1:0] alu_result,
  input  logic            alu_zero,
  output logic            zero_flag,
  output logic            busy
);

  localparam int unsigned NB = bits / 8;
  localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  fe_state_e       state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   tx_k_q;
  logic [31:0]     idle_q;
  logic            started_q;
  logic [bits-1:0] a_q;
  logic [bits-1:0] b_q;
  logic [3:0]      op_q;
  logic [bits-1:0] res_q;
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic            zero_q;
  logic            busy_q;
  logic            timeout_hit;

  // Idle counting only runs once a byte of the current frame has arrived.
  assign timeout_hit = (TIMEOUT_CYC != 0) && started_q && (idle_q == TIMEOUT_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_A;
      k_q        <= '0;
      tx_k_q     <= '0;
      idle_q     <= '0;
      started_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        RX_A, RX_B: begin
          if (rx_done) begin
            for (int unsigned i = 0; i < NB; i++) begin
              if (k_q == KW'(i)) begin
                if (state_q == RX_A) a_q[i*8 +: 8] <= rx_data;
                else                 b_q[i*8 +: 8] <= rx_data;
              end
            end
            started_q <= 1'b1;
            idle_q    <= '0;
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= (state_q == RX_A) ? RX_B : RX_OP;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end else if (timeout_hit) begin
            state_q   <= RX_A;
            k_q       <= '0;
            idle_q    <= '0;
            started_q <= 1'b0;
          end else if (started_q) begin
            idle_q <= idle_q + 32'd1;
          end
        end
        RX_OP: begin
          if (rx_done) begin
            op_q      <= rx_data[3:0];
            busy_q    <= 1'b1;
            started_q <= 1'b0;
            idle_q    <= '0;
            state_q   <= EXEC;
          end else if (timeout_hit) begin
            state_q   <= RX_A;
            k_q       <= '0;
            idle_q    <= '0;
            started_q <= 1'b0;
          end else if (started_q) begin
            idle_q <= idle_q + 32'd1;
          end
        end
        EXEC: begin
          // res_q holds the bytes still to send, next one in the low byte.
          res_q      <= alu_result >> 8;
          tx_data_q  <= alu_result[7:0];
          zero_q     <= alu_zero;
          tx_start_q <= 1'b1;
          tx_k_q     <= '0;
          state_q    <= TX_WAIT;
        end
        TX_WAIT: begin
          // A tx_done seen while our own tx_start is still high is stale.
          if (tx_done && !tx_start_q) begin
            if (tx_k_q == K_LAST) begin
              busy_q  <= 1'b0;
              tx_k_q  <= '0;
              state_q <= RX_A;
            end else begin
              tx_k_q     <= tx_k_q + KW'(1);
              tx_data_q  <= res_q[7:0];
              res_q      <= res_q >> 8;
              tx_start_q <= 1'b1;
            end
          end
        end
        default: state_q <= RX_A;
      endcase
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign zero_flag = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_uart_frontend.sv
module tb_alu_uart_frontend;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       rx_done8, tx_done8, tx_start8, zero8, busy8, alu_zero8;
  logic [7:0] rx_data8, tx_data8, a8, b8, res8;
  logic [3:0] op8;

  logic        rx_done16, tx_done16, tx_start16, zero16, busy16, alu_zero16;
  logic [7:0]  rx_data16, tx_data16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  op16;

  alu_uart_frontend #(.bits(8), .TIMEOUT_CYC(20)) dut8 (
    .clk(clk), .rst(rst), .rx_done(rx_done8), .rx_data(rx_data8), .tx_done(tx_done8),
    .tx_start(tx_start8), .tx_data(tx_data8), .alu_a(a8), .alu_b(b8), .alu_op(op8),
    .alu_result(res8), .alu_zero(alu_zero8), .zero_flag(zero8), .busy(busy8)
  );

  alu_uart_frontend #(.bits(16), .TIMEOUT_CYC(20)) dut16 (
    .clk(clk), .rst(rst), .rx_done(rx_done16), .rx_data(rx_data16), .tx_done(tx_done16),
    .tx_start(tx_start16), .tx_data(tx_data16), .alu_a(a16), .alu_b(b16), .alu_op(op16),
    .alu_result(res16), .alu_zero(alu_zero16), .zero_flag(zero16), .busy(busy16)
  );

  // Behavioural ALU of width w, used both as the DUTs' environment and as the
  // reference for expected result bytes.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input int unsigned w);
    int unsigned mask, ua, ub, sh, r;
    int sa;
    mask = (32'd1 << w) - 32'd1;
    ua   = 32'(a) & mask;
    ub   = 32'(b) & mask;
    sh   = ub % w;
    sa   = (((ua >> (w - 1)) & 32'd1) != 0) ? int'(ua) - int'(32'd1 << w) : int'(ua);
    case (op)
      ALU_AND: r = ua & ub;
      ALU_OR:  r = ua | ub;
      ALU_ADD: r = ua + ub;
      ALU_SRA: r = unsigned'(sa >>> sh);
      ALU_SRL: r = ua >> sh;
      ALU_NOR: r = ~(ua | ub);
      ALU_SUB: r = ua - ub;
      ALU_XOR: r = ua ^ ub;
      ALU_SLL: r = ua << sh;
      default: r = '1;
    endcase
    return 16'(r & mask);
  endfunction

  always_comb begin
    res8       = 8'(alu_f({8'h00, a8}, {8'h00, b8}, op8, 8));
    alu_zero8  = (res8 == '0);
    res16      = alu_f(a16, b16, op16, 16);
    alu_zero16 = (res16 == '0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input int gap);
    rx_data8 = d;
    rx_done8 = 1'b1;
    @(negedge clk);
    rx_done8 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send16(input logic [7:0] d);
    rx_data16 = d;
    rx_done16 = 1'b1;
    @(negedge clk);
    rx_done16 = 1'b0;
  endtask

  // mode: 0 normal, 1 tx_done during tx_start, 2 rx byte during TX_WAIT,
  //       3 reset while in TX_WAIT
  task automatic run_frame8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [7:0] exp, input logic expz, input int gap,
                            input int mode, input string name);
    logic [3:0] opn;
    opn = opb[3:0];
    send8(a, gap);
    send8(b, gap);
    send8(opb, 0);
    check({name, ".alu_a"}, a8, a);
    check({name, ".alu_b"}, b8, b);
    check({name, ".alu_op"}, op8, opn);
    check({name, ".busy_exec"}, busy8, 1);
    check({name, ".no_start_e0"}, tx_start8, 0);
    @(negedge clk);
    check({name, ".tx_start"}, tx_start8, 1);
    check({name, ".tx_data"}, tx_data8, exp);
    check({name, ".zero_flag"}, zero8, expz);
    if (mode == 1) tx_done8 = 1'b1;
    @(negedge clk);
    tx_done8 = 1'b0;
    check({name, ".start_width"}, tx_start8, 0);
    check({name, ".busy_wait"}, busy8, 1);
    if (mode == 2) begin
      rx_data8 = 8'hFF;
      rx_done8 = 1'b1;
      @(negedge clk);
      rx_done8 = 1'b0;
      check({name, ".drop_a"}, a8, a);
      check({name, ".drop_b"}, b8, b);
      check({name, ".drop_op"}, op8, opn);
    end
    if (mode == 3) begin
      #2 rst = 1'b1;
      #1;
      check({name, ".rst_a"}, a8, 0);
      check({name, ".rst_b"}, b8, 0);
      check({name, ".rst_op"}, op8, 0);
      check({name, ".rst_start"}, tx_start8, 0);
      check({name, ".rst_data"}, tx_data8, 0);
      check({name, ".rst_zero"}, zero8, 0);
      check({name, ".rst_busy"}, busy8, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end else begin
      repeat (2) @(negedge clk);
      check({name, ".no_extra_start"}, tx_start8, 0);
      check({name, ".tx_hold"}, tx_data8, exp);
      check({name, ".busy_hold"}, busy8, 1);
      tx_done8 = 1'b1;
      @(negedge clk);
      tx_done8 = 1'b0;
      check({name, ".busy_done"}, busy8, 0);
      check({name, ".no_start_done"}, tx_start8, 0);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] res;
    logic       z;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] ra, rb, ropb, rexp;

    vecs[0]  = '{8'h05, 8'h03, {4'h0, ALU_ADD}, 8'h08, 1'b0};
    vecs[1]  = '{8'h07, 8'h07, {4'h0, ALU_SUB}, 8'h00, 1'b1};
    vecs[2]  = '{8'h09, 8'h07, {4'h0, ALU_SUB}, 8'h02, 1'b0};
    vecs[3]  = '{8'h01, 8'h02, {4'h0, ALU_OR},  8'h03, 1'b0};
    vecs[4]  = '{8'hF0, 8'h3C, {4'h0, ALU_AND}, 8'h30, 1'b0};
    vecs[5]  = '{8'h0F, 8'hF0, {4'h0, ALU_NOR}, 8'h00, 1'b1};
    vecs[6]  = '{8'hAA, 8'hFF, {4'h0, ALU_XOR}, 8'h55, 1'b0};
    vecs[7]  = '{8'h81, 8'h03, {4'h0, ALU_SLL}, 8'h08, 1'b0};
    vecs[8]  = '{8'h80, 8'h01, {4'h0, ALU_SRA}, 8'hC0, 1'b0};
    vecs[9]  = '{8'h80, 8'h01, {4'h0, ALU_SRL}, 8'h40, 1'b0};
    vecs[10] = '{8'h12, 8'h34, 8'h07,           8'hFF, 1'b0};
    vecs[11] = '{8'h10, 8'h20, 8'hF2,           8'h30, 1'b0};
    vecs[12] = '{8'hFF, 8'h01, {4'h0, ALU_ADD}, 8'h00, 1'b1};

    rst = 1'b1;
    rx_done8 = 1'b0; rx_data8 = '0; tx_done8 = 1'b0;
    rx_done16 = 1'b0; rx_data16 = '0; tx_done16 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst8.a", a8, 0);
    check("rst8.b", b8, 0);
    check("rst8.op", op8, 0);
    check("rst8.tx_start", tx_start8, 0);
    check("rst8.tx_data", tx_data8, 0);
    check("rst8.zero", zero8, 0);
    check("rst8.busy", busy8, 0);
    check("rst16.a", a16, 0);
    check("rst16.tx_start", tx_start16, 0);
    check("rst16.busy", busy16, 0);
    rst = 1'b0;
    @(negedge clk);

    // 16-bit frame, back-to-back bytes, two result bytes.
    send16(8'h34); send16(8'h12); send16(8'h01); send16(8'h00); send16(8'h02);
    check("w16.a", a16, 32'h1234);
    check("w16.b", b16, 32'h0001);
    check("w16.op", op16, 2);
    check("w16.busy", busy16, 1);
    check("w16.no_start_e0", tx_start16, 0);
    @(negedge clk);
    check("w16.start0", tx_start16, 1);
    check("w16.data0", tx_data16, 8'h35);
    check("w16.zero", zero16, 0);
    tx_done16 = 1'b1;
    @(negedge clk);
    tx_done16 = 1'b0;
    check("w16.stale_done", tx_start16, 0);
    check("w16.busy_mid", busy16, 1);
    repeat (3) @(negedge clk);
    check("w16.wait_start", tx_start16, 0);
    check("w16.wait_data", tx_data16, 8'h35);
    tx_done16 = 1'b1;
    @(negedge clk);
    tx_done16 = 1'b0;
    check("w16.start1", tx_start16, 1);
    check("w16.data1", tx_data16, 8'h12);
    check("w16.busy1", busy16, 1);
    @(negedge clk);
    check("w16.width1", tx_start16, 0);
    repeat (3) @(negedge clk);
    tx_done16 = 1'b1;
    @(negedge clk);
    tx_done16 = 1'b0;
    check("w16.busy_end", busy16, 0);
    check("w16.no_start_end", tx_start16, 0);
    repeat (3) @(negedge clk);
    check("w16.idle_start", tx_start16, 0);
    check("w16.idle_data", tx_data16, 8'h12);

    for (int i = 0; i < 13; i++)
      run_frame8(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].res, vecs[i].z, 0, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ropb = 8'($urandom);
      rexp = 8'(alu_f({8'h00, ra}, {8'h00, rb}, ropb[3:0], 8));
      run_frame8(ra, rb, ropb, rexp, rexp == 8'h00, int'($urandom_range(0, 4)), 0,
                 $sformatf("rnd%0d", i));
    end

    // Abandoned frame: lone byte then long silence.
    send8(8'h05, 0);
    check("tmo.a_loaded", a8, 8'h05);
    repeat (25) @(negedge clk);
    check("tmo.a_kept", a8, 8'h05);
    check("tmo.busy", busy8, 0);
    run_frame8(8'h01, 8'h01, {4'h0, ALU_ADD}, 8'h02, 1'b0, 0, 0, "tmo");

    run_frame8(8'h03, 8'h04, {4'h0, ALU_ADD}, 8'h07, 1'b0, 10, 0, "slow");
    run_frame8(8'h10, 8'h20, {4'h0, ALU_XOR}, 8'h30, 1'b0, 0, 1, "early_done");
    run_frame8(8'hAA, 8'h55, {4'h0, ALU_ADD}, 8'hFF, 1'b0, 0, 2, "drop");
    run_frame8(8'h01, 8'h02, {4'h0, ALU_OR},  8'h03, 1'b0, 0, 0, "after_drop");
    run_frame8(8'h07, 8'h07, {4'h0, ALU_SUB}, 8'h00, 1'b1, 0, 3, "rst_tx");
    run_frame8(8'h05, 8'h03, {4'h0, ALU_ADD}, 8'h08, 1'b0, 0, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
